// File: rtl/mcycle_dispatch_if.sv
// Request / issue / writeback / hazard signal bundle for the mul/div dispatch controller.
// slave is the dispatch side; master is the pipeline plus multi-cycle unit side.
interface mcycle_dispatch_if #(
    parameter int width = 32
);
    logic             ReqValid;
    logic             ReqReady;
    logic             ReqOp;
    logic [width-1:0] ReqOp1;
    logic [width-1:0] ReqOp2;
    logic [3:0]       ReqWA3;
    logic             MStart;
    logic             MOp;
    logic [width-1:0] MOperand1;
    logic [width-1:0] MOperand2;
    logic [3:0]       MWA3;
    logic             MBusy;
    logic             MDone;
    logic [width-1:0] MResult;
    logic             WBValid;
    logic [width-1:0] WBData;
    logic [3:0]       WBAddr;
    logic             WBAccept;
    logic [3:0]       RA1;
    logic [3:0]       RA2;
    logic             Hazard1;
    logic             Hazard2;

    modport slave (
        input  ReqValid, ReqOp, ReqOp1, ReqOp2, ReqWA3,
        input  MBusy, MDone, MResult, WBAccept, RA1, RA2,
        output ReqReady, MStart, MOp, MOperand1, MOperand2, MWA3,
        output WBValid, WBData, WBAddr, Hazard1, Hazard2
    );

    modport master (
        output ReqValid, ReqOp, ReqOp1, ReqOp2, ReqWA3,
        output MBusy, MDone, MResult, WBAccept, RA1, RA2,
        input  ReqReady, MStart, MOp, MOperand1, MOperand2, MWA3,
        input  WBValid, WBData, WBAddr, Hazard1, Hazard2
    );
endinterface

// File: rtl/mcycle_dispatch.sv
// Queues MUL/DIV requests, issues them one at a time to the multi-cycle unit,
// holds each result for writeback and flags RAW hazards on pending destinations.
module mcycle_dispatch #(
    parameter int width = 32,
    parameter int DEPTH = 2
) (
    input logic             CLK,
    input logic             Reset,
    mcycle_dispatch_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;

    typedef struct packed {
        logic             op;
        logic [width-1:0] op1;
        logic [width-1:0] op2;
        logic [3:0]       wa3;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    state_e           state_q, state_d;
    logic [3:0]       inflight_wa_q, inflight_wa_d;
    logic             wb_valid_q, wb_valid_d;
    logic [width-1:0] wb_data_q, wb_data_d;
    logic [3:0]       wb_addr_q, wb_addr_d;

    logic   full, empty, push, start;
    entry_t head;
    logic [PW-1:0] offs;
    logic   haz1, haz2;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.ReqValid && !full;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        state_d       = state_q;
        start         = 1'b0;
        inflight_wa_d = inflight_wa_q;
        wb_valid_d    = wb_valid_q;
        wb_data_d     = wb_data_q;
        wb_addr_d     = wb_addr_q;
        case (state_q)
            IDLE: begin
                if (!empty && !bus.MBusy) begin
                    start         = 1'b1;
                    inflight_wa_d = head.wa3;
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                if (bus.MDone) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = bus.MResult;
                    wb_addr_d  = inflight_wa_q;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (bus.WBAccept) begin
                    wb_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pop happens only on the issue cycle; push and pop together leave count unchanged.
    always_comb begin
        wr_ptr_d = push  ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = start ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !start)
            count_d = count_q + CW'(1);
        else if (!push && start)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            inflight_wa_q <= '0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= '0;
            wb_addr_q     <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            inflight_wa_q <= inflight_wa_d;
            wb_valid_q    <= wb_valid_d;
            wb_data_q     <= wb_data_d;
            wb_addr_q     <= wb_addr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem_q[wr_ptr_q] <= '{op: bus.ReqOp, op1: bus.ReqOp1, op2: bus.ReqOp2, wa3: bus.ReqWA3};
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        haz1 = 1'b0;
        haz2 = 1'b0;
        offs = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - rd_ptr_q;
            if ({1'b0, offs} < count_q) begin
                if (mem_q[i].wa3 == bus.RA1) haz1 = 1'b1;
                if (mem_q[i].wa3 == bus.RA2) haz2 = 1'b1;
            end
        end
        if (state_q == WAIT) begin
            if (inflight_wa_q == bus.RA1) haz1 = 1'b1;
            if (inflight_wa_q == bus.RA2) haz2 = 1'b1;
        end
        if (wb_valid_q) begin
            if (wb_addr_q == bus.RA1) haz1 = 1'b1;
            if (wb_addr_q == bus.RA2) haz2 = 1'b1;
        end
    end

    assign bus.ReqReady  = !full;
    assign bus.MStart    = start;
    assign bus.MOp       = head.op;
    assign bus.MOperand1 = head.op1;
    assign bus.MOperand2 = head.op2;
    assign bus.MWA3      = head.wa3;
    assign bus.WBValid   = wb_valid_q;
    assign bus.WBData    = wb_data_q;
    assign bus.WBAddr    = wb_addr_q;
    assign bus.Hazard1   = haz1;
    assign bus.Hazard2   = haz2;
endmodule

// File: tb/tb_mcycle_dispatch.sv
// Directed bench for mcycle_dispatch; the bench itself plays the multi-cycle unit.
module tb_mcycle_dispatch;
    logic CLK = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    mcycle_dispatch_if #(.width(32)) bus ();

    mcycle_dispatch #(.width(32), .DEPTH(2)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_req(input logic op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] wa);
        bus.ReqValid = 1'b1;
        bus.ReqOp    = op;
        bus.ReqOp1   = a;
        bus.ReqOp2   = b;
        bus.ReqWA3   = wa;
    endtask

    task automatic done_pulse(input logic [31:0] r);
        bus.MBusy   = 1'b0;
        bus.MDone   = 1'b1;
        bus.MResult = r;
        step();
        bus.MDone   = 1'b0;
        bus.MResult = '0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        #1;
        checks++; if (bus.WBValid !== 1'b0) begin errors++; $display("FAIL rst_wbvalid: got %b want 0", bus.WBValid); end
        checks++; if (bus.WBData !== 32'd0) begin errors++; $display("FAIL rst_wbdata: got %0d want 0", bus.WBData); end
        checks++; if (bus.WBAddr !== 4'd0) begin errors++; $display("FAIL rst_wbaddr: got %0d want 0", bus.WBAddr); end
        checks++; if (bus.MStart !== 1'b0) begin errors++; $display("FAIL rst_mstart: got %b want 0", bus.MStart); end
        checks++; if (bus.ReqReady !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.ReqReady); end
    endtask

    task automatic test_multiply();
        push_req(1'b0, 32'd7, 32'd6, 4'd3);
        bus.WBAccept = 1'b1;
        #1;
        checks++; if (bus.MStart !== 1'b0) begin errors++; $display("FAIL mul_no_bypass: got %b want 0", bus.MStart); end
        step();
        bus.ReqValid = 1'b0;
        #1;
        checks++; if (bus.MStart !== 1'b1) begin errors++; $display("FAIL mul_start: got %b want 1", bus.MStart); end
        checks++; if ({bus.MOp, bus.MOperand1, bus.MOperand2, bus.MWA3} !== {1'b0, 32'd7, 32'd6, 4'd3})
            begin errors++; $display("FAIL mul_issue: got op=%b %0d %0d wa=%0d want op=0 7 6 wa=3", bus.MOp, bus.MOperand1, bus.MOperand2, bus.MWA3); end
        step();
        bus.MBusy = 1'b1;
        #1;
        checks++; if (bus.MStart !== 1'b0) begin errors++; $display("FAIL mul_pulse_width: got %b want 0", bus.MStart); end
        step();
        step();
        done_pulse(32'd42);
        #1;
        checks++; if (bus.WBValid !== 1'b1) begin errors++; $display("FAIL mul_wbvalid: got %b want 1", bus.WBValid); end
        checks++; if (bus.WBData !== 32'd42) begin errors++; $display("FAIL mul_wbdata: got %0d want 42", bus.WBData); end
        checks++; if (bus.WBAddr !== 4'd3) begin errors++; $display("FAIL mul_wbaddr: got %0d want 3", bus.WBAddr); end
        step();
        checks++; if (bus.WBValid !== 1'b0) begin errors++; $display("FAIL mul_wbclear: got %b want 0", bus.WBValid); end
        bus.WBAccept = 1'b0;
    endtask

    task automatic test_divide();
        push_req(1'b1, 32'd100, 32'd7, 4'd9);
        step();
        bus.ReqValid = 1'b0;
        #1;
        checks++; if ({bus.MStart, bus.MOp, bus.MOperand1, bus.MOperand2} !== {1'b1, 1'b1, 32'd100, 32'd7})
            begin errors++; $display("FAIL div_issue: got start=%b op=%b %0d %0d want 1 1 100 7", bus.MStart, bus.MOp, bus.MOperand1, bus.MOperand2); end
        step();
        bus.MBusy = 1'b1;
        step();
        done_pulse(32'd14);
        bus.WBAccept = 1'b1;
        #1;
        checks++; if ({bus.WBValid, bus.WBData, bus.WBAddr} !== {1'b1, 32'd14, 4'd9})
            begin errors++; $display("FAIL div_wb: got v=%b %0d@%0d want 1 14@9", bus.WBValid, bus.WBData, bus.WBAddr); end
        step();
        bus.WBAccept = 1'b0;
    endtask

    task automatic test_back_to_back();
        push_req(1'b0, 32'd3, 32'd5, 4'd1);
        step();
        push_req(1'b1, 32'd8, 32'd2, 4'd2);
        #1;
        checks++; if ({bus.MStart, bus.MOperand1, bus.MWA3} !== {1'b1, 32'd3, 4'd1})
            begin errors++; $display("FAIL b2b_first_issue: got start=%b op1=%0d wa=%0d want 1 3 1", bus.MStart, bus.MOperand1, bus.MWA3); end
        step();
        bus.ReqValid = 1'b0;
        bus.MBusy    = 1'b1;
        bus.RA1      = 4'd1;
        bus.RA2      = 4'd2;
        #1;
        checks++; if (bus.Hazard1 !== 1'b1) begin errors++; $display("FAIL b2b_haz_inflight: got %b want 1", bus.Hazard1); end
        checks++; if (bus.Hazard2 !== 1'b1) begin errors++; $display("FAIL b2b_haz_queued: got %b want 1", bus.Hazard2); end
        step();
        done_pulse(32'd15);
        #1;
        checks++; if ({bus.WBValid, bus.WBData, bus.WBAddr} !== {1'b1, 32'd15, 4'd1})
            begin errors++; $display("FAIL b2b_wb1: got v=%b %0d@%0d want 1 15@1", bus.WBValid, bus.WBData, bus.WBAddr); end
        checks++; if (bus.MStart !== 1'b0) begin errors++; $display("FAIL b2b_no_issue_in_hold: got %b want 0", bus.MStart); end
        bus.WBAccept = 1'b1;
        step();
        bus.WBAccept = 1'b0;
        #1;
        checks++; if ({bus.MStart, bus.MOperand1, bus.MWA3} !== {1'b1, 32'd8, 4'd2})
            begin errors++; $display("FAIL b2b_second_issue: got start=%b op1=%0d wa=%0d want 1 8 2", bus.MStart, bus.MOperand1, bus.MWA3); end
        step();
        done_pulse(32'd4);
        #1;
        checks++; if ({bus.WBValid, bus.WBData, bus.WBAddr} !== {1'b1, 32'd4, 4'd2})
            begin errors++; $display("FAIL b2b_wb2: got v=%b %0d@%0d want 1 4@2", bus.WBValid, bus.WBData, bus.WBAddr); end
        bus.WBAccept = 1'b1;
        step();
        bus.WBAccept = 1'b0;
        bus.RA1 = 4'd0;
        bus.RA2 = 4'd0;
    endtask

    task automatic test_full_queue();
        bus.MBusy = 1'b1;
        push_req(1'b0, 32'd1, 32'd1, 4'd5);
        step();
        push_req(1'b0, 32'd2, 32'd2, 4'd6);
        step();
        push_req(1'b0, 32'd3, 32'd3, 4'd7);
        #1;
        checks++; if (bus.ReqReady !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", bus.ReqReady); end
        step();
        bus.ReqValid = 1'b0;
        bus.MBusy    = 1'b0;
        #1;
        checks++; if ({bus.MStart, bus.MWA3} !== {1'b1, 4'd5})
            begin errors++; $display("FAIL full_issue_a: got start=%b wa=%0d want 1 5", bus.MStart, bus.MWA3); end
        step();
        checks++; if (bus.ReqReady !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b want 1", bus.ReqReady); end
        done_pulse(32'd1);
        bus.WBAccept = 1'b1;
        step();
        bus.WBAccept = 1'b0;
        bus.RA1      = 4'd7;
        #1;
        checks++; if ({bus.MStart, bus.MWA3} !== {1'b1, 4'd6})
            begin errors++; $display("FAIL full_issue_b: got start=%b wa=%0d want 1 6", bus.MStart, bus.MWA3); end
        checks++; if (bus.Hazard1 !== 1'b0) begin errors++; $display("FAIL full_extra_not_stored: got %b want 0", bus.Hazard1); end
        step();
        done_pulse(32'd4);
        bus.WBAccept = 1'b1;
        step();
        bus.WBAccept = 1'b0;
        #1;
        checks++; if (bus.MStart !== 1'b0) begin errors++; $display("FAIL full_drained: got %b want 0", bus.MStart); end
        bus.RA1 = 4'd0;
    endtask

    task automatic test_backpressure_hazard();
        push_req(1'b0, 32'd2, 32'd9, 4'd11);
        step();
        bus.ReqValid = 1'b0;
        step();
        push_req(1'b0, 32'd1, 32'd1, 4'd12);
        step();
        bus.ReqValid = 1'b0;
        done_pulse(32'd18);
        bus.RA1 = 4'd11;
        bus.RA2 = 4'd4;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({bus.WBValid, bus.WBData, bus.WBAddr} !== {1'b1, 32'd18, 4'd11})
                begin errors++; $display("FAIL bp_hold_%0d: got v=%b %0d@%0d want 1 18@11", i, bus.WBValid, bus.WBData, bus.WBAddr); end
            checks++; if (bus.MStart !== 1'b0) begin errors++; $display("FAIL bp_no_start_%0d: got %b want 0", i, bus.MStart); end
            checks++; if ({bus.Hazard1, bus.Hazard2} !== 2'b10)
                begin errors++; $display("FAIL bp_hazard_%0d: got %b%b want 10", i, bus.Hazard1, bus.Hazard2); end
            step();
        end
        bus.WBAccept = 1'b1;
        step();
        bus.WBAccept = 1'b0;
        bus.RA1 = 4'd0;
        bus.RA2 = 4'd0;
        #1;
        checks++; if ({bus.MStart, bus.MWA3} !== {1'b1, 4'd12})
            begin errors++; $display("FAIL bp_next_issue: got start=%b wa=%0d want 1 12", bus.MStart, bus.MWA3); end
        step();
        done_pulse(32'd1);
        bus.WBAccept = 1'b1;
        step();
        bus.WBAccept = 1'b0;
        done_pulse(32'd99);
        #1;
        checks++; if (bus.WBValid !== 1'b0) begin errors++; $display("FAIL mdone_in_idle: got %b want 0", bus.WBValid); end
    endtask

    task automatic test_reset_in_wait();
        push_req(1'b0, 32'd4, 32'd4, 4'd13);
        step();
        push_req(1'b0, 32'd5, 32'd5, 4'd14);
        step();
        bus.ReqValid = 1'b0;
        bus.MBusy    = 1'b1;
        Reset        = 1'b1;
        step();
        Reset     = 1'b0;
        bus.MBusy = 1'b0;
        bus.RA1   = 4'd13;
        bus.RA2   = 4'd14;
        #1;
        checks++; if ({bus.ReqReady, bus.WBValid, bus.MStart} !== 3'b100)
            begin errors++; $display("FAIL rstw_state: got ready=%b wbv=%b start=%b want 1 0 0", bus.ReqReady, bus.WBValid, bus.MStart); end
        checks++; if ({bus.Hazard1, bus.Hazard2} !== 2'b00)
            begin errors++; $display("FAIL rstw_hazard: got %b%b want 00", bus.Hazard1, bus.Hazard2); end
        done_pulse(32'd55);
        #1;
        checks++; if ({bus.WBValid, bus.WBData} !== {1'b0, 32'd0})
            begin errors++; $display("FAIL rstw_late_done: got v=%b data=%0d want 0 0", bus.WBValid, bus.WBData); end
    endtask

    initial begin
        Reset        = 1'b1;
        bus.ReqValid = 1'b0;
        bus.ReqOp    = 1'b0;
        bus.ReqOp1   = '0;
        bus.ReqOp2   = '0;
        bus.ReqWA3   = '0;
        bus.MBusy    = 1'b0;
        bus.MDone    = 1'b0;
        bus.MResult  = '0;
        bus.WBAccept = 1'b0;
        bus.RA1      = '0;
        bus.RA2      = '0;
        test_reset();
        test_multiply();
        test_divide();
        test_back_to_back();
        test_full_queue();
        test_backpressure_hazard();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/mcycle_dispatch.md
Name: mcycle_dispatch

Overview:
- Pipeline-side controller for the multi-cycle multiply/divide unit. Sits between decode/execute and that unit.
- Accepts MUL/DIV requests from execute into a small queue and issues them one at a time using a Start pulse.
- Captures the result when the unit signals Done, then presents it to the register-file writeback arbiter with a valid/accept handshake.
- Provides hazard flags for source registers whose value is still pending in the queue, in flight, or awaiting writeback.

Parameters:
- width, 32, operand/result datapath width.
- DEPTH, 2, request queue entries (power of two, >=2).

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- ReqValid  input  1  execute presents a MUL/DIV request.
- ReqReady  output  1  queue can accept a request this cycle.
- ReqOp  input  1  0 = multiply, 1 = divide.
- ReqOp1  input  width  multiplicand / dividend.
- ReqOp2  input  width  multiplier / divisor.
- ReqWA3  input  4  destination register.
- MStart  output  1  one-cycle start pulse to the multi-cycle unit.
- MOp  output  1  operation for the issued request.
- MOperand1  output  width  issued operand 1.
- MOperand2  output  width  issued operand 2.
- MWA3  output  4  issued destination register.
- MBusy  input  1  multi-cycle unit busy.
- MDone  input  1  one-cycle result-ready pulse from the unit.
- MResult  input  width  result from the unit, sampled on MDone.
- WBValid  output  1  captured result awaiting writeback.
- WBData  output  width  result data.
- WBAddr  output  4  result destination register.
- WBAccept  input  1  arbiter accepts the result this cycle (ALU writeback has priority).
- RA1, RA2  input  4 each  source registers being decoded.
- Hazard1, Hazard2  output  1 each  corresponding RA matches a pending destination.

Behaviour:
- Reset: queue emptied, FSM to IDLE; WBValid=0, WBData=0, WBAddr=0, MStart=0. Reset mid-operation discards all queued, in-flight and held results with no writeback; the multi-cycle unit shares the same Reset.
- Queue: FIFO with registered storage. ReqReady = ~full. Push on ReqValid&ReqReady. Pop only on an MStart cycle. A pushed entry becomes visible the next cycle; there is no bypass from push to issue in the same cycle.
- Simultaneous push and pop is allowed when not full. Count is unchanged and pointers wrap modulo DEPTH.
- FSM IDLE: MStart=1 combinationally when queue non-empty and MBusy=0. MOp/MOperand1/MOperand2/MWA3 driven from the queue head. Pop and go to WAIT.
- FSM WAIT: MStart=0. On MDone, register MResult into WBData and MWA3 (latched at issue) into WBAddr, set WBValid=1, go to HOLD.
- FSM HOLD: WBValid held with stable data until WBAccept=1. On accept, clear WBValid and go to IDLE. No new issue occurs while in HOLD.
- Latency: request accepted at cycle 0 into an empty queue with idle unit -> MStart at cycle 1. MDone at cycle k -> WBValid at cycle k+1. Accept at cycle j -> next MStart no earlier than j+1.
- MDone outside WAIT is ignored.
- WBAccept while WBValid=0 is ignored.
- Hazard: HazardN = RAN equals WA3 of any valid queue entry, or the in-flight destination (state WAIT), or WBAddr while WBValid. Purely combinational.

Test Plan:
- Multiply: ReqOp=0, ReqOp1=7, ReqOp2=6, ReqWA3=3, WBAccept=1 -> MStart pulse of exactly 1 cycle one cycle after accept; after MDone, WBValid=1, WBData=42, WBAddr=3, then WBValid=0 the next cycle.
- Divide: ReqOp=1, ReqOp1=100, ReqOp2=7, ReqWA3=9 -> WBData=14, WBAddr=9.
- Back-to-back: push 3*5 (WA3=1), then 8/2 (WA3=2) on consecutive cycles -> writebacks in order 15@R1 then 4@R2; second MStart only after the first accept.
- Full queue: push DEPTH requests while the unit is busy -> ReqReady=0; an extra ReqValid is not stored. After one pop, ReqReady=1 again.
- Backpressure and hazard: hold WBAccept=0 for 3 cycles after MDone -> WBValid and WBData stable, no MStart. During that window, Hazard1=1 when RA1=WBAddr and 0 for an unrelated register.
- Reset during WAIT -> the next cycle shows empty queue, ReqReady=1, WBValid=0, Hazard1/2=0. A later MDone produces no writeback.
